// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory port arbiter: FSM states, mux select
// codes and the select-to-one-hot conversion used for grants and acks.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [1:0] SEL_R0   = 2'b00;
    localparam logic [1:0] SEL_R1   = 2'b01;
    localparam logic [1:0] SEL_R2   = 2'b10;
    localparam logic [1:0] SEL_NONE = 2'b11;

    // Map a requester index / select code to its one-hot grant vector.
    // SEL_NONE maps to no requester at all.
    function automatic logic [2:0] sel_to_onehot(input logic [1:0] sel);
        logic [2:0] onehot;
        case (sel)
            SEL_R0:  onehot = 3'b001;
            SEL_R1:  onehot = 3'b010;
            SEL_R2:  onehot = 3'b100;
            default: onehot = 3'b000;
        endcase
        return onehot;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_mux3.sv
// Generic 3:1 multiplexer steering one requester's field onto the shared
// memory port. Select 11 means no requester and drives zero.
module mux3 #(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] out
);

    // Pure combinational select; unused code yields zero.
    always_comb begin
        case (sel)
            2'b00:   out = in0;
            2'b01:   out = in1;
            2'b10:   out = in2;
            default: out = '0;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and sequencer for the single shared memory port.
// Three requesters compete; the winner's address, write data and write
// enable are steered onto the port through mux3 instances while a
// valid/ready handshake with bounded wait runs the transaction.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        I_clk,
    input  logic        I_rst_n,
    input  logic [2:0]  I_req,
    input  logic [31:0] I_addr0,
    input  logic [31:0] I_addr1,
    input  logic [31:0] I_addr2,
    input  logic [31:0] I_wdata0,
    input  logic [31:0] I_wdata1,
    input  logic [31:0] I_wdata2,
    input  logic [2:0]  I_we,
    output logic [2:0]  O_gnt,
    output logic [1:0]  O_sel,
    output logic [31:0] O_mem_addr,
    output logic [31:0] O_mem_wdata,
    output logic        O_mem_we,
    output logic        O_mem_valid,
    input  logic        I_mem_ready,
    input  logic [31:0] I_mem_rdata,
    output logic [31:0] O_rdata,
    output logic [2:0]  O_ack,
    output logic        O_err
);

    // Counter only needs to reach TIMEOUT-1, so it never wraps.
    localparam int              CNT_W     = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [2:0]         gnt_q, gnt_d;
    logic [1:0]         sel_q, sel_d;
    logic [1:0]         last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;
    logic [1:0]         pick_win;
    logic               we_mux;

    // Round-robin search starting just after the last winner and wrapping.
    function automatic logic [1:0] rr_pick(input logic [2:0] req,
                                           input logic [1:0] last);
        logic [1:0] win;
        win = SEL_R0;
        case (last)
            2'd0: begin
                if (req[1])      win = SEL_R1;
                else if (req[2]) win = SEL_R2;
                else             win = SEL_R0;
            end
            2'd1: begin
                if (req[2])      win = SEL_R2;
                else if (req[0]) win = SEL_R0;
                else             win = SEL_R1;
            end
            default: begin
                if (req[0])      win = SEL_R0;
                else if (req[1]) win = SEL_R1;
                else             win = SEL_R2;
            end
        endcase
        return win;
    endfunction

    assign pick_win = rr_pick(I_req, last_q);

    // State and datapath registers; reset aborts any transaction at once.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= 3'b000;
            sel_q   <= SEL_NONE;
            last_q  <= SEL_R2;
            cnt_q   <= '0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: arbitrate in IDLE, wait for ready or timeout in
    // BUSY, and spend exactly one cycle in RESP for the ack pulse.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|I_req) begin
                    state_d = ST_BUSY;
                    gnt_d   = sel_to_onehot(pick_win);
                    sel_d   = pick_win;
                    last_d  = pick_win;
                    cnt_d   = '0;
                end
            end
            ST_BUSY: begin
                if (I_mem_ready) begin
                    rdata_d = I_mem_rdata;
                    state_d = ST_RESP;
                    sel_d   = SEL_NONE;
                end else if (cnt_q == CNT_LIMIT) begin
                    state_d = ST_RESP;
                    sel_d   = SEL_NONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                gnt_d   = 3'b000;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 3'b000;
                sel_d   = SEL_NONE;
            end
        endcase
    end

    mux3 #(.WIDTH(32)) u_addr_mux (
        .sel (sel_q),
        .in0 (I_addr0),
        .in1 (I_addr1),
        .in2 (I_addr2),
        .out (O_mem_addr)
    );

    mux3 #(.WIDTH(32)) u_wdata_mux (
        .sel (sel_q),
        .in0 (I_wdata0),
        .in1 (I_wdata1),
        .in2 (I_wdata2),
        .out (O_mem_wdata)
    );

    mux3 #(.WIDTH(1)) u_we_mux (
        .sel (sel_q),
        .in0 (I_we[0]),
        .in1 (I_we[1]),
        .in2 (I_we[2]),
        .out (we_mux)
    );

    assign O_gnt       = gnt_q;
    assign O_sel       = sel_q;
    assign O_mem_valid = (state_q == ST_BUSY);
    assign O_mem_we    = we_mux & O_mem_valid;
    assign O_rdata     = rdata_q;
    assign O_ack       = (state_q == ST_RESP) ? sel_to_onehot(last_q) : 3'b000;
    assign O_err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter with TIMEOUT = 4. Expected completions are
// queued when a transaction is launched and popped when the ack appears.
module tb_mem_port_arbiter;

    typedef struct {
        logic [2:0]  ack;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        I_clk;
    logic        I_rst_n;
    logic [2:0]  I_req;
    logic [31:0] I_addr0, I_addr1, I_addr2;
    logic [31:0] I_wdata0, I_wdata1, I_wdata2;
    logic [2:0]  I_we;
    logic [2:0]  O_gnt;
    logic [1:0]  O_sel;
    logic [31:0] O_mem_addr, O_mem_wdata;
    logic        O_mem_we, O_mem_valid;
    logic        I_mem_ready;
    logic [31:0] I_mem_rdata;
    logic [31:0] O_rdata;
    logic [2:0]  O_ack;
    logic        O_err;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    mem_port_arbiter #(.TIMEOUT(4)) dut (
        .I_clk       (I_clk),
        .I_rst_n     (I_rst_n),
        .I_req       (I_req),
        .I_addr0     (I_addr0),
        .I_addr1     (I_addr1),
        .I_addr2     (I_addr2),
        .I_wdata0    (I_wdata0),
        .I_wdata1    (I_wdata1),
        .I_wdata2    (I_wdata2),
        .I_we        (I_we),
        .O_gnt       (O_gnt),
        .O_sel       (O_sel),
        .O_mem_addr  (O_mem_addr),
        .O_mem_wdata (O_mem_wdata),
        .O_mem_we    (O_mem_we),
        .O_mem_valid (O_mem_valid),
        .I_mem_ready (I_mem_ready),
        .I_mem_rdata (I_mem_rdata),
        .O_rdata     (O_rdata),
        .O_ack       (O_ack),
        .O_err       (O_err)
    );

    initial I_clk = 1'b0;
    always #5 I_clk = ~I_clk;

    task automatic test_reset();
        I_rst_n = 1'b0;
        I_req = 3'b000; I_we = 3'b000; I_mem_ready = 1'b0;
        I_addr0 = 32'h0; I_addr1 = 32'h0; I_addr2 = 32'h0;
        I_wdata0 = 32'h0; I_wdata1 = 32'h0; I_wdata2 = 32'h0;
        I_mem_rdata = 32'h0;
        repeat (2) @(negedge I_clk);
        checks++; if (O_gnt !== 3'b000) begin failures++; $display("[TB] FAIL reset_gnt actual=%b expected=000", O_gnt); end
        checks++; if (O_sel !== 2'b11) begin failures++; $display("[TB] FAIL reset_sel actual=%b expected=11", O_sel); end
        checks++; if (O_mem_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid actual=%b expected=0", O_mem_valid); end
        checks++; if (O_ack !== 3'b000) begin failures++; $display("[TB] FAIL reset_ack actual=%b expected=000", O_ack); end
        checks++; if (O_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err actual=%b expected=0", O_err); end
        checks++; if (O_rdata !== 32'h0) begin failures++; $display("[TB] FAIL reset_rdata actual=%h expected=0", O_rdata); end
        I_rst_n = 1'b1;
        @(negedge I_clk);
        checks++; if (O_mem_valid !== 1'b0) begin failures++; $display("[TB] FAIL idle_valid actual=%b expected=0", O_mem_valid); end
    endtask

    task automatic test_single_read();
        exp_t e;
        bit   got = 0;
        I_addr0 = 32'h100; I_we = 3'b000; I_req = 3'b001;
        @(negedge I_clk);
        checks++; if (O_mem_valid !== 1'b1) begin failures++; $display("[TB] FAIL rd_valid actual=%b expected=1", O_mem_valid); end
        checks++; if (O_sel !== 2'b00) begin failures++; $display("[TB] FAIL rd_sel actual=%b expected=00", O_sel); end
        checks++; if (O_gnt !== 3'b001) begin failures++; $display("[TB] FAIL rd_gnt actual=%b expected=001", O_gnt); end
        checks++; if (O_mem_addr !== 32'h100) begin failures++; $display("[TB] FAIL rd_addr actual=%h expected=00000100", O_mem_addr); end
        checks++; if (O_mem_we !== 1'b0) begin failures++; $display("[TB] FAIL rd_we actual=%b expected=0", O_mem_we); end
        I_mem_ready = 1'b1; I_mem_rdata = 32'hDEADBEEF;
        sb.push_back('{3'b001, 32'hDEADBEEF, 1'b0});
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge I_clk);
            if (O_ack !== 3'b000 && sb.size() > 0) begin
                got = 1;
                e = sb.pop_front();
                checks++; if (O_ack !== e.ack) begin failures++; $display("[TB] FAIL rd_ack actual=%b expected=%b", O_ack, e.ack); end
                checks++; if (O_rdata !== e.rdata) begin failures++; $display("[TB] FAIL rd_rdata actual=%h expected=%h", O_rdata, e.rdata); end
                checks++; if (O_err !== e.err) begin failures++; $display("[TB] FAIL rd_err actual=%b expected=%b", O_err, e.err); end
                checks++; if (c !== 0) begin failures++; $display("[TB] FAIL rd_latency actual=%0d expected=0", c); end
                I_req = 3'b000; I_mem_ready = 1'b0;
            end
        end
        checks++; if (!got) begin failures++; $display("[TB] FAIL rd_ack_timeout actual=none expected=ack"); end
        @(negedge I_clk);
        checks++; if (O_ack !== 3'b000) begin failures++; $display("[TB] FAIL rd_ack_pulse actual=%b expected=000", O_ack); end
    endtask

    task automatic test_all_held();
        exp_t e;
        bit   done = 0;
        int   prev = -1;
        I_req = 3'b111; I_mem_ready = 1'b1; I_mem_rdata = 32'hCAFE0001;
        sb.push_back('{3'b010, 32'hCAFE0001, 1'b0});
        sb.push_back('{3'b100, 32'hCAFE0001, 1'b0});
        sb.push_back('{3'b001, 32'hCAFE0001, 1'b0});
        sb.push_back('{3'b010, 32'hCAFE0001, 1'b0});
        sb.push_back('{3'b100, 32'hCAFE0001, 1'b0});
        sb.push_back('{3'b001, 32'hCAFE0001, 1'b0});
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge I_clk);
            if (O_ack !== 3'b000 && sb.size() > 0) begin
                e = sb.pop_front();
                checks++; if (O_ack !== e.ack) begin failures++; $display("[TB] FAIL rr_ack actual=%b expected=%b", O_ack, e.ack); end
                checks++; if (O_err !== e.err) begin failures++; $display("[TB] FAIL rr_err actual=%b expected=%b", O_err, e.err); end
                if (prev >= 0) begin
                    checks++; if (c - prev !== 3) begin failures++; $display("[TB] FAIL rr_spacing actual=%0d expected=3", c - prev); end
                end
                prev = c;
                if (sb.size() == 0) begin
                    done = 1;
                    I_req = 3'b000; I_mem_ready = 1'b0;
                end
            end
        end
        checks++; if (!done) begin failures++; $display("[TB] FAIL rr_ack_timeout actual=%0d_left expected=0_left", sb.size()); end
        sb.delete();
        I_req = 3'b000; I_mem_ready = 1'b0;
        @(negedge I_clk);
    endtask

    task automatic test_write();
        exp_t e;
        bit   got = 0;
        I_addr1 = 32'h200; I_wdata1 = 32'h12345678; I_wdata0 = 32'hFFFFFFFF;
        I_we = 3'b010; I_req = 3'b010; I_mem_ready = 1'b0;
        #1;
        checks++; if (O_mem_we !== 1'b0) begin failures++; $display("[TB] FAIL wr_we_idle actual=%b expected=0", O_mem_we); end
        @(negedge I_clk);
        checks++; if (O_mem_we !== 1'b1) begin failures++; $display("[TB] FAIL wr_we_busy actual=%b expected=1", O_mem_we); end
        checks++; if (O_mem_wdata !== 32'h12345678) begin failures++; $display("[TB] FAIL wr_wdata actual=%h expected=12345678", O_mem_wdata); end
        checks++; if (O_mem_addr !== 32'h200) begin failures++; $display("[TB] FAIL wr_addr actual=%h expected=00000200", O_mem_addr); end
        @(negedge I_clk);
        checks++; if (O_sel !== 2'b01) begin failures++; $display("[TB] FAIL wr_sel_held actual=%b expected=01", O_sel); end
        checks++; if (O_gnt !== 3'b010) begin failures++; $display("[TB] FAIL wr_gnt_held actual=%b expected=010", O_gnt); end
        I_mem_ready = 1'b1; I_mem_rdata = 32'h00000055;
        sb.push_back('{3'b010, 32'h00000055, 1'b0});
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge I_clk);
            if (O_ack !== 3'b000 && sb.size() > 0) begin
                got = 1;
                e = sb.pop_front();
                checks++; if (O_ack !== e.ack) begin failures++; $display("[TB] FAIL wr_ack actual=%b expected=%b", O_ack, e.ack); end
                checks++; if (O_rdata !== e.rdata) begin failures++; $display("[TB] FAIL wr_rdata actual=%h expected=%h", O_rdata, e.rdata); end
                checks++; if (O_mem_we !== 1'b0) begin failures++; $display("[TB] FAIL wr_we_resp actual=%b expected=0", O_mem_we); end
                checks++; if (O_sel !== 2'b11) begin failures++; $display("[TB] FAIL wr_sel_resp actual=%b expected=11", O_sel); end
                I_req = 3'b000; I_we = 3'b000; I_mem_ready = 1'b0;
            end
        end
        checks++; if (!got) begin failures++; $display("[TB] FAIL wr_ack_timeout actual=none expected=ack"); end
        I_req = 3'b000; I_we = 3'b000; I_mem_ready = 1'b0;
        @(negedge I_clk);
    endtask

    task automatic test_timeout();
        exp_t e;
        bit   got = 0;
        int   vcnt = 0;
        I_addr0 = 32'h300; I_req = 3'b001; I_mem_ready = 1'b0; I_mem_rdata = 32'hBAD0BAD0;
        sb.push_back('{3'b001, 32'h00000055, 1'b1});
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge I_clk);
            if (O_mem_valid === 1'b1) vcnt++;
            if (O_ack !== 3'b000 && sb.size() > 0) begin
                got = 1;
                e = sb.pop_front();
                checks++; if (O_ack !== e.ack) begin failures++; $display("[TB] FAIL to_ack actual=%b expected=%b", O_ack, e.ack); end
                checks++; if (O_err !== e.err) begin failures++; $display("[TB] FAIL to_err actual=%b expected=%b", O_err, e.err); end
                checks++; if (O_rdata !== e.rdata) begin failures++; $display("[TB] FAIL to_rdata actual=%h expected=%h", O_rdata, e.rdata); end
                checks++; if (vcnt !== 4) begin failures++; $display("[TB] FAIL to_valid_cycles actual=%0d expected=4", vcnt); end
                I_req = 3'b000;
            end
        end
        checks++; if (!got) begin failures++; $display("[TB] FAIL to_ack_timeout actual=none expected=ack"); end
        I_req = 3'b000;
        @(negedge I_clk);
        checks++; if (O_err !== 1'b0) begin failures++; $display("[TB] FAIL to_err_pulse actual=%b expected=0", O_err); end
    endtask

    task automatic test_boundary();
        exp_t e;
        bit   got = 0;
        int   vcnt = 0;
        I_addr2 = 32'h400; I_req = 3'b100; I_mem_ready = 1'b0;
        sb.push_back('{3'b100, 32'h44444444, 1'b0});
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge I_clk);
            if (O_mem_valid === 1'b1) begin
                vcnt++;
                if (vcnt == 4) begin
                    I_mem_ready = 1'b1; I_mem_rdata = 32'h44444444;
                end
            end
            if (O_ack !== 3'b000 && sb.size() > 0) begin
                got = 1;
                e = sb.pop_front();
                checks++; if (O_ack !== e.ack) begin failures++; $display("[TB] FAIL bd_ack actual=%b expected=%b", O_ack, e.ack); end
                checks++; if (O_err !== e.err) begin failures++; $display("[TB] FAIL bd_err actual=%b expected=%b", O_err, e.err); end
                checks++; if (O_rdata !== e.rdata) begin failures++; $display("[TB] FAIL bd_rdata actual=%h expected=%h", O_rdata, e.rdata); end
                checks++; if (vcnt !== 4) begin failures++; $display("[TB] FAIL bd_valid_cycles actual=%0d expected=4", vcnt); end
                I_req = 3'b000; I_mem_ready = 1'b0;
            end
        end
        checks++; if (!got) begin failures++; $display("[TB] FAIL bd_ack_timeout actual=none expected=ack"); end
        I_req = 3'b000; I_mem_ready = 1'b0;
        @(negedge I_clk);
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bit   got = 0;
        I_req = 3'b110; I_mem_ready = 1'b0;
        @(negedge I_clk);
        checks++; if (O_gnt !== 3'b010) begin failures++; $display("[TB] FAIL rm_pre_gnt actual=%b expected=010", O_gnt); end
        I_rst_n = 1'b0;
        #1;
        checks++; if (O_mem_valid !== 1'b0) begin failures++; $display("[TB] FAIL rm_valid actual=%b expected=0", O_mem_valid); end
        checks++; if (O_gnt !== 3'b000) begin failures++; $display("[TB] FAIL rm_gnt actual=%b expected=000", O_gnt); end
        checks++; if (O_sel !== 2'b11) begin failures++; $display("[TB] FAIL rm_sel actual=%b expected=11", O_sel); end
        checks++; if (O_rdata !== 32'h0) begin failures++; $display("[TB] FAIL rm_rdata actual=%h expected=0", O_rdata); end
        checks++; if (O_err !== 1'b0) begin failures++; $display("[TB] FAIL rm_err actual=%b expected=0", O_err); end
        @(negedge I_clk);
        checks++; if (O_ack !== 3'b000) begin failures++; $display("[TB] FAIL rm_no_ack actual=%b expected=000", O_ack); end
        I_req = 3'b111;
        I_rst_n = 1'b1;
        @(negedge I_clk);
        checks++; if (O_gnt !== 3'b001) begin failures++; $display("[TB] FAIL rm_post_gnt actual=%b expected=001", O_gnt); end
        checks++; if (O_sel !== 2'b00) begin failures++; $display("[TB] FAIL rm_post_sel actual=%b expected=00", O_sel); end
        I_mem_ready = 1'b1; I_mem_rdata = 32'h00000077;
        sb.push_back('{3'b001, 32'h00000077, 1'b0});
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge I_clk);
            if (O_ack !== 3'b000 && sb.size() > 0) begin
                got = 1;
                e = sb.pop_front();
                checks++; if (O_ack !== e.ack) begin failures++; $display("[TB] FAIL rm_ack actual=%b expected=%b", O_ack, e.ack); end
                checks++; if (O_rdata !== e.rdata) begin failures++; $display("[TB] FAIL rm_rdata_after actual=%h expected=%h", O_rdata, e.rdata); end
                I_req = 3'b000; I_mem_ready = 1'b0;
            end
        end
        checks++; if (!got) begin failures++; $display("[TB] FAIL rm_ack_timeout actual=none expected=ack"); end
        I_req = 3'b000; I_mem_ready = 1'b0;
        @(negedge I_clk);
        checks++; if (sb.size() !== 0) begin failures++; $display("[TB] FAIL sb_leftover actual=%0d expected=0", sb.size()); end
    endtask

    // Scenarios run in order; each relies on the round-robin pointer the
    // previous one left behind.
    initial begin
        test_reset();
        test_single_read();
        test_all_held();
        test_write();
        test_timeout();
        test_boundary();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
